multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// ---------------
// Control FSM for the multicycle 64-bit RISC-V datapath. One instruction
// moves through FETCH, DECODE, an execute/address state, an optional memory
// state and a writeback state. Every datapath enable, mux select and ALU
// operation comes from this block. An unsupported encoding parks the FSM in
// HALT until reset.
//
// Ports
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   op, funct3, funct7_5   instruction fields taken from the IR
//   z                      ALU zero flag (combinational, used in BRANCH)
//   imem_ready, dmem_ready memory handshakes (only with MC_MEM_WAIT_EN)
//   pc_write, pc_src       PC load enable / PC source (0 = ALU, 1 = ALU-out reg)
//   load_ir                IR and old-PC register load
//   mux_a_sel, mux_b_sel   ALU operand selects
//   ula_sel                ALU operation (1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR)
//   dmem_write             data memory write strobe
//   regfile_write, wb_sel  register file write and writeback source
//   instr_done             one-cycle pulse in the last state of an instruction
//   halted                 high while in HALT
//   state                  current state code, for debug
//
// Build option
//   MC_MEM_WAIT_EN  when defined, FETCH, MEM_RD and MEM_WR wait for the
//                   memory ready inputs; otherwise both are ignored.

module multicycle_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       z,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       pc_write,
    output logic       pc_src,
    output logic       load_ir,
    output logic [2:0] mux_a_sel,
    output logic [2:0] mux_b_sel,
    output logic [3:0] ula_sel,
    output logic       dmem_write,
    output logic       regfile_write,
    output logic [2:0] wb_sel,
    output logic       instr_done,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_ALU = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_LUI    = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;

    state_t     state_q, state_d;
    logic       pc_write_q, pc_write_d;
    logic       pc_src_q, pc_src_d;
    logic       load_ir_q, load_ir_d;
    logic [2:0] mux_a_sel_q, mux_a_sel_d;
    logic [2:0] mux_b_sel_q, mux_b_sel_d;
    logic [3:0] ula_sel_q, ula_sel_d;
    logic       dmem_write_q, dmem_write_d;
    logic       regfile_write_q, regfile_write_d;
    logic [2:0] wb_sel_q, wb_sel_d;
    logic       instr_done_q, instr_done_d;
    logic       halted_q, halted_d;

    logic imem_ok;
    logic dmem_ok;
    logic branch_taken;

`ifdef MC_MEM_WAIT_EN
    assign imem_ok = imem_ready;
    assign dmem_ok = dmem_ready;
`else
    // Without the wait option the memories always complete in one cycle.
    logic unused_ready;
    assign unused_ready = imem_ready | dmem_ready;
    assign imem_ok      = 1'b1;
    assign dmem_ok      = 1'b1;
`endif

    // The ALU operation shared by R-type and I-type; funct7_5 only picks SUB
    // when the caller allows it (I-type always passes 0).
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic sub);
        logic [3:0] r;
        r = 4'd0;
        case (f3)
            3'b000:  r = sub ? ALU_SUB : ALU_ADD;
            3'b111:  r = ALU_AND;
            3'b110:  r = ALU_OR;
            3'b100:  r = ALU_XOR;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    function automatic logic alu_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b100) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Branch resolution stays combinational so pc_write follows z within the
    // BRANCH cycle instead of a cycle late.
    assign branch_taken = ((funct3 == 3'b000) & z) | ((funct3 == 3'b001) & ~z);

    // Next-state logic: DECODE validates the opcode and funct3 before
    // committing to a path, so an unsupported encoding never reaches a state
    // that asserts a write enable.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = imem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_R:      state_d = alu_f3_ok(funct3) ? S_EXEC_R : S_HALT;
                    OP_I:      state_d = alu_f3_ok(funct3) ? S_EXEC_I : S_HALT;
                    OP_LOAD,
                    OP_STORE:  state_d = (funct3 == 3'b011) ? S_ADDR : S_HALT;
                    OP_BRANCH: state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? S_BRANCH : S_HALT;
                    OP_LUI:    state_d = S_LUI;
                    default:   state_d = S_HALT;
                endcase
            end
            S_EXEC_R: state_d = S_WB_ALU;
            S_EXEC_I: state_d = S_WB_ALU;
            S_ADDR:   state_d = (op == OP_LOAD)  ? S_MEM_RD :
                                (op == OP_STORE) ? S_MEM_WR : S_HALT;
            S_MEM_RD: state_d = dmem_ok ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR: state_d = dmem_ok ? S_FETCH : S_MEM_WR;
            S_WB_ALU: state_d = S_FETCH;
            S_WB_MEM: state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_LUI:    state_d = S_WB_ALU;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // Output decode of the state being entered. Registering these gives
    // glitch-free Moore outputs that line up with state_q, and an async reset
    // clears every enable at the same instant as the state.
    always_comb begin
        pc_write_d      = 1'b0;
        pc_src_d        = 1'b0;
        load_ir_d       = 1'b0;
        mux_a_sel_d     = 3'd0;
        mux_b_sel_d     = 3'd0;
        ula_sel_d       = 4'd0;
        dmem_write_d    = 1'b0;
        regfile_write_d = 1'b0;
        wb_sel_d        = 3'd0;
        instr_done_d    = 1'b0;
        halted_d        = 1'b0;
        case (state_d)
            S_FETCH: begin
                load_ir_d   = 1'b1;
                mux_a_sel_d = 3'd0;
                mux_b_sel_d = 3'd1;
                ula_sel_d   = ALU_ADD;
                pc_write_d  = 1'b1;
            end
            S_DECODE: begin
                mux_a_sel_d = 3'd2;
                mux_b_sel_d = 3'd3;
                ula_sel_d   = ALU_ADD;
            end
            S_EXEC_R: begin
                mux_a_sel_d = 3'd1;
                mux_b_sel_d = 3'd0;
                ula_sel_d   = alu_op(funct3, funct7_5);
            end
            S_EXEC_I: begin
                mux_a_sel_d = 3'd1;
                mux_b_sel_d = 3'd2;
                ula_sel_d   = alu_op(funct3, 1'b0);
            end
            S_ADDR: begin
                mux_a_sel_d = 3'd1;
                mux_b_sel_d = 3'd2;
                ula_sel_d   = ALU_ADD;
            end
            S_MEM_WR: begin
                dmem_write_d = 1'b1;
                instr_done_d = 1'b1;
            end
            S_WB_ALU: begin
                regfile_write_d = 1'b1;
                wb_sel_d        = 3'd0;
                instr_done_d    = 1'b1;
            end
            S_WB_MEM: begin
                regfile_write_d = 1'b1;
                wb_sel_d        = 3'd1;
                instr_done_d    = 1'b1;
            end
            S_BRANCH: begin
                mux_a_sel_d  = 3'd1;
                mux_b_sel_d  = 3'd0;
                ula_sel_d    = ALU_SUB;
                pc_src_d     = 1'b1;
                instr_done_d = 1'b1;
            end
            S_LUI: begin
                mux_a_sel_d = 3'd3;
                mux_b_sel_d = 3'd2;
                ula_sel_d   = ALU_ADD;
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                halted_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs share one register bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_INIT;
            pc_write_q      <= 1'b0;
            pc_src_q        <= 1'b0;
            load_ir_q       <= 1'b0;
            mux_a_sel_q     <= 3'd0;
            mux_b_sel_q     <= 3'd0;
            ula_sel_q       <= 4'd0;
            dmem_write_q    <= 1'b0;
            regfile_write_q <= 1'b0;
            wb_sel_q        <= 3'd0;
            instr_done_q    <= 1'b0;
            halted_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_write_q      <= pc_write_d;
            pc_src_q        <= pc_src_d;
            load_ir_q       <= load_ir_d;
            mux_a_sel_q     <= mux_a_sel_d;
            mux_b_sel_q     <= mux_b_sel_d;
            ula_sel_q       <= ula_sel_d;
            dmem_write_q    <= dmem_write_d;
            regfile_write_q <= regfile_write_d;
            wb_sel_q        <= wb_sel_d;
            instr_done_q    <= instr_done_d;
            halted_q        <= halted_d;
        end
    end

    // The fetch strobes are suppressed while instruction memory is not ready,
    // and a waiting store only retires in the cycle its memory accepts it.
    assign pc_write      = (pc_write_q & imem_ok) | ((state_q == S_BRANCH) & branch_taken);
    assign load_ir       = load_ir_q & imem_ok;
    assign instr_done    = instr_done_q & ((state_q != S_MEM_WR) | dmem_ok);
    assign pc_src        = pc_src_q;
    assign mux_a_sel     = mux_a_sel_q;
    assign mux_b_sel     = mux_b_sel_q;
    assign ula_sel       = ula_sel_q;
    assign dmem_write    = dmem_write_q;
    assign regfile_write = regfile_write_q;
    assign wb_sel        = wb_sel_q;
    assign halted        = halted_q;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. Stimulus issues one instruction at a time
// and pushes a predicted per-instruction summary into a queue; a monitor on
// the falling edge accumulates what the controller did and compares it when
// the instruction retires or halts.

module tb_multicycle_ctrl;

    logic       clock;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       z;
    logic       imem_ready;
    logic       dmem_ready;
    logic       pc_write;
    logic       pc_src;
    logic       load_ir;
    logic [2:0] mux_a_sel;
    logic [2:0] mux_b_sel;
    logic [3:0] ula_sel;
    logic       dmem_write;
    logic       regfile_write;
    logic [2:0] wb_sel;
    logic       instr_done;
    logic       halted;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clock(clock),
        .reset(reset),
        .op(op),
        .funct3(funct3),
        .funct7_5(funct7_5),
        .z(z),
        .imem_ready(imem_ready),
        .dmem_ready(dmem_ready),
        .pc_write(pc_write),
        .pc_src(pc_src),
        .load_ir(load_ir),
        .mux_a_sel(mux_a_sel),
        .mux_b_sel(mux_b_sel),
        .ula_sel(ula_sel),
        .dmem_write(dmem_write),
        .regfile_write(regfile_write),
        .wb_sel(wb_sel),
        .instr_done(instr_done),
        .halted(halted),
        .state(state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // What one instruction is expected to do, summarised from the ISA rules.
    typedef struct {
        int halt;
        int cycles;
        int rf_writes;
        int dm_writes;
        int wb;
        int pc_taken;
        int exec_ula;
        int exec_b;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   retired  = 0;
    int   halt_cycles = 0;

    task automatic checkOutput(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int alu_code(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? 2 : 1;
            3'b111:  return 3;
            3'b110:  return 4;
            3'b100:  return 5;
            default: return -1;
        endcase
    endfunction

    // Reference model: instruction class decides length, writes and ALU use.
    function automatic exp_t predict(input logic [6:0] o, input logic [2:0] f3,
                                     input logic f75, input logic zz, input int dwait);
        exp_t e;
        e = '{default: 0};
        e.halt = 1;
        case (o)
            7'b0110011: if (alu_code(f3, f75) > 0) begin
                e = '{halt: 0, cycles: 4, rf_writes: 1, dm_writes: 0, wb: 0,
                      pc_taken: 0, exec_ula: alu_code(f3, f75), exec_b: 0};
            end
            7'b0010011: if (alu_code(f3, 1'b0) > 0) begin
                e = '{halt: 0, cycles: 4, rf_writes: 1, dm_writes: 0, wb: 0,
                      pc_taken: 0, exec_ula: alu_code(f3, 1'b0), exec_b: 2};
            end
            7'b0000011: if (f3 == 3'b011) begin
                e = '{halt: 0, cycles: 5 + dwait, rf_writes: 1, dm_writes: 0, wb: 1,
                      pc_taken: 0, exec_ula: 1, exec_b: 2};
            end
            7'b0100011: if (f3 == 3'b011) begin
                e = '{halt: 0, cycles: 4 + dwait, rf_writes: 0, dm_writes: 1 + dwait, wb: 0,
                      pc_taken: 0, exec_ula: 1, exec_b: 2};
            end
            7'b1100011: if (f3 == 3'b000 || f3 == 3'b001) begin
                e = '{halt: 0, cycles: 3, rf_writes: 0, dm_writes: 0, wb: 0,
                      pc_taken: (f3 == 3'b000) ? int'(zz) : int'(!zz),
                      exec_ula: 2, exec_b: 0};
            end
            7'b0110111: begin
                e = '{halt: 0, cycles: 4, rf_writes: 1, dm_writes: 0, wb: 0,
                      pc_taken: 0, exec_ula: 1, exec_b: 2};
            end
            default: e.halt = 1;
        endcase
        if (e.halt != 0) e.cycles = 3;
        return e;
    endfunction

    // Monitor: samples on the falling edge, far from the active edge.
    initial begin
        logic [3:0] prev_state;
        int   active, in_halt, cyc, rfw, dmw, obs_wb, obs_ula, obs_b;
        exp_t e;
        prev_state = 4'd0;
        active = 0; in_halt = 0;
        cyc = 0; rfw = 0; dmw = 0; obs_wb = 0; obs_ula = 0; obs_b = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                active  = 0;
                in_halt = 0;
            end else begin
                if (state == 4'd1 && prev_state != 4'd1) begin
                    active = 1; cyc = 0; rfw = 0; dmw = 0; obs_wb = 0;
                    checkOutput("fetch_load_ir", load_ir, 1);
                    checkOutput("fetch_pc_write", pc_write, 1);
                end
                if (active != 0) begin
                    cyc++;
                    rfw += int'(regfile_write);
                    dmw += int'(dmem_write);
                    if (regfile_write) obs_wb = int'(wb_sel);
                    if (cyc == 3) begin
                        obs_ula = int'(ula_sel);
                        obs_b   = int'(mux_b_sel);
                    end
                    if (instr_done || halted) begin
                        if (exp_q.size() == 0) begin
                            checkOutput("unexpected_retire", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            checkOutput("halt_flag", int'(halted), e.halt);
                            checkOutput("cycles", cyc, e.cycles);
                            if (e.halt == 0) begin
                                checkOutput("rf_writes", rfw, e.rf_writes);
                                checkOutput("dm_writes", dmw, e.dm_writes);
                                if (e.rf_writes > 0) checkOutput("wb_sel", obs_wb, e.wb);
                                checkOutput("pc_taken", int'(pc_write), e.pc_taken);
                                checkOutput("exec_ula", obs_ula, e.exec_ula);
                                checkOutput("exec_b", obs_b, e.exec_b);
                            end
                        end
                        if (halted) begin
                            in_halt     = 1;
                            halt_cycles = 0;
                        end
                        active = 0;
                        retired++;
                    end
                end
                if (in_halt != 0) begin
                    halt_cycles++;
                    checkOutput("halt_halted", halted, 1);
                    checkOutput("halt_enables",
                                {pc_write, load_ir, dmem_write, regfile_write, instr_done}, 0);
                end
            end
            prev_state = state;
        end
    end

    task automatic doReset();
        reset = 1'b1;
        #1;
        checkOutput("reset_state", state, 0);
        checkOutput("reset_outputs",
                    {pc_write, pc_src, load_ir, mux_a_sel, mux_b_sel, ula_sel,
                     dmem_write, regfile_write, wb_sel, instr_done, halted}, 0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic waitState(input logic [3:0] s, input string name);
        int n;
        n = 0;
        #1;
        while (state != s && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 200) checkOutput(name, state, s);
    endtask

    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                                 input logic f75, input logic zz, input int dwait);
        int n, prev;
        waitState(4'd1, "fetch_timeout");
        op = o; funct3 = f3; funct7_5 = f75; z = zz;
        exp_q.push_back(predict(o, f3, f75, zz, dwait));
        prev = retired;
        if (dwait > 0) begin
            waitState(4'd5, "addr_timeout");
            dmem_ready = 1'b0;
            repeat (dwait + 1) @(posedge clock);
            #1;
            dmem_ready = 1'b1;
        end
        n = 0;
        while (retired == prev && n < 200) begin
            @(posedge clock);
            n++;
        end
        if (n >= 200) checkOutput("retire_timeout", 0, 1);
    endtask

    task automatic haltTest(input logic [6:0] o, input logic [2:0] f3);
        applyStimulus(o, f3, 1'b0, 1'b0, 0);
        repeat (11) @(posedge clock);
        #1;
        checkOutput("halt_held_10", int'(halt_cycles >= 10), 1);
        checkOutput("halt_state", state, 12);
        doReset();
    endtask

    logic [2:0] alu_f3 [4];

    initial begin
        int cls;
        logic [2:0] f3;
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cls;
        logic [2:0] f3;
        alu_f3[0] = 3'b000; alu_f3[1] = 3'b100; alu_f3[2] = 3'b110; alu_f3[3] = 3'b111;
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; z = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        doReset();

        // Directed instructions covering each class and both branch senses.
        applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b0, 0);
        applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0, 0);
        applyStimulus(7'b0010011, 3'b100, 1'b0, 1'b0, 0);
        applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0, 0);
        applyStimulus(7'b0000011, 3'b011, 1'b0, 1'b0, 0);
        applyStimulus(7'b0100011, 3'b011, 1'b0, 1'b0, 0);
        applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1, 0);
        applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b0, 0);
        applyStimulus(7'b1100011, 3'b001, 1'b0, 1'b1, 0);
        applyStimulus(7'b1100011, 3'b001, 1'b0, 1'b0, 0);
        applyStimulus(7'b0110111, 3'b101, 1'b1, 1'b0, 0);
        applyStimulus(7'b0110011, 3'b111, 1'b0, 1'b0, 0);
        applyStimulus(7'b0110011, 3'b110, 1'b0, 1'b0, 0);

        // Random stream of supported encodings.
        for (int i = 0; i < 40; i++) begin
            cls = int'($urandom_range(0, 5));
            f3  = alu_f3[$urandom_range(0, 3)];
            case (cls)
                0: applyStimulus(7'b0110011, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
                1: applyStimulus(7'b0010011, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
                2: applyStimulus(7'b0000011, 3'b011, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
                3: applyStimulus(7'b0100011, 3'b011, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
                4: applyStimulus(7'b1100011, 3'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 0);
                default: applyStimulus(7'b0110111, 3'($urandom_range(0, 7)), 1'b0, 1'($urandom_range(0, 1)), 0);
            endcase
        end
        checkOutput("queue_empty", exp_q.size(), 0);

        // Reset in the middle of a store drops the write strobe at once.
        waitState(4'd1, "fetch_timeout");
        op = 7'b0100011; funct3 = 3'b011;
        waitState(4'd7, "memwr_timeout");
        checkOutput("memwr_dmem_write", dmem_write, 1);
        doReset();

        // Unsupported encodings halt without retiring.
        haltTest(7'b1111111, 3'b000);
        haltTest(7'b0110011, 3'b001);
        haltTest(7'b0010011, 3'b010);
        haltTest(7'b0000011, 3'b010);
        haltTest(7'b1100011, 3'b100);

`ifdef MC_MEM_WAIT_EN
        // Store held by a slow data memory, then a fetch held by instruction memory.
        applyStimulus(7'b0100011, 3'b011, 1'b0, 1'b0, 3);
        waitState(4'd1, "fetch_timeout");
        imem_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("fetch_hold_state", state, 1);
        checkOutput("fetch_hold_load_ir", load_ir, 0);
        checkOutput("fetch_hold_pc_write", pc_write, 0);
        imem_ready = 1'b1;
        doReset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
